// File: rtl/breakout_spi_pkg.sv
// Shared constants for the breakout SPI slave:
// register map, status bit positions, data width.
package breakout_spi_pkg;
  localparam int DATA_W = 8;

  localparam logic [2:0] ADDR_RXDATA  = 3'd0;
  localparam logic [2:0] ADDR_TXDATA  = 3'd1;
  localparam logic [2:0] ADDR_STATUS  = 3'd2;
  localparam logic [2:0] ADDR_CONTROL = 3'd3;

  localparam int BIT_ROE  = 3;
  localparam int BIT_TOE  = 4;
  localparam int BIT_TUE  = 5;
  localparam int BIT_TRDY = 6;
  localparam int BIT_RRDY = 7;
  localparam int BIT_E    = 8;
endpackage

// File: rtl/breakout_spi_slave_sync.sv
// Multi-flop synchronizer with rise/fall detect
// on the synchronized value.
module spi_sync_edge #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset_n,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall
);
  logic [STAGES-1:0] sync;
  logic              q_d;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync <= {STAGES{RST_VAL}};
      q_d  <= RST_VAL;
    end else begin
      sync[0] <= d;
      for (int i = 1; i < STAGES; i++)
        sync[i] <= sync[i-1];
      q_d <= sync[STAGES-1];
    end
  end

  assign q    = sync[STAGES-1];
  assign rise = q & ~q_d;
  assign fall = ~q & q_d;
endmodule

// File: rtl/breakout_spi_slave.sv
// SPI mode-0 slave with CPU register port:
// rxdata, txdata, status, control; one byte deep each way.
module breakout_spi_slave
  import breakout_spi_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        SCLK,
  input  logic        SS_n,
  input  logic        MOSI,
  output logic        MISO,
  output logic        MISO_oe,
  input  logic [2:0]  mem_addr,
  input  logic [15:0] data_from_cpu,
  input  logic        read_n,
  input  logic        write_n,
  input  logic        spi_select,
  output logic [15:0] data_to_cpu,
  output logic        irq,
  output logic        dataavailable,
  output logic        readyfordata
);
  logic sclk_q, sclk_rise, sclk_fall;
  logic ss_q, ss_rise, ss_fall;
  logic mosi_q, mosi_rise, mosi_fall;

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sclk (
    .clk(clk), .reset_n(reset_n), .d(SCLK),
    .q(sclk_q), .rise(sclk_rise), .fall(sclk_fall));
  spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_ss (
    .clk(clk), .reset_n(reset_n), .d(SS_n),
    .q(ss_q), .rise(ss_rise), .fall(ss_fall));
  spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_mosi (
    .clk(clk), .reset_n(reset_n), .d(MOSI),
    .q(mosi_q), .rise(mosi_rise), .fall(mosi_fall));

  logic [DATA_W-1:0] rx_shift, rx_holding;
  logic [DATA_W-1:0] tx_shift, tx_holding;
  logic [3:0]        bit_cnt;
  logic              primed, rrdy, roe, toe, tue;
  logic [BIT_E:BIT_ROE] ie;
  logic              rd_p1, wr_p1;
  logic [15:0]       status, ctrl_word, rd_mux;

  logic rd_req, wr_req, rd_stb, wr_stb;
  logic active, shift_fall, load_ev, rx_done;
  logic [DATA_W-1:0] rx_next;

  assign rd_req = spi_select & ~read_n;
  assign wr_req = spi_select & ~write_n;
  assign rd_stb = rd_req & ~rd_p1;
  assign wr_stb = wr_req & ~wr_p1;

  assign active     = ~ss_q;
  assign shift_fall = sclk_fall & active;
  assign load_ev    = ss_fall | (shift_fall & (bit_cnt == 4'd8));
  assign rx_next    = {rx_shift[DATA_W-2:0], mosi_q};
  assign rx_done    = sclk_rise & active & (bit_cnt == 4'd7);

  always_comb begin
    status = '0;
    status[BIT_ROE]  = roe;
    status[BIT_TOE]  = toe;
    status[BIT_TUE]  = tue;
    status[BIT_TRDY] = ~primed;
    status[BIT_RRDY] = rrdy;
    status[BIT_E]    = roe | toe | tue;
    ctrl_word = '0;
    ctrl_word[BIT_E:BIT_ROE] = ie;
    unique case (mem_addr)
      ADDR_STATUS:  rd_mux = status;
      ADDR_CONTROL: rd_mux = ctrl_word;
      default:      rd_mux = {8'h00, rx_holding};
    endcase
  end

  // Later assignments win: event sets override CPU clears.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rx_shift    <= '0;
      rx_holding  <= '0;
      tx_shift    <= '0;
      tx_holding  <= '0;
      bit_cnt     <= '0;
      primed      <= 1'b0;
      rrdy        <= 1'b0;
      roe         <= 1'b0;
      toe         <= 1'b0;
      tue         <= 1'b0;
      ie          <= '0;
      rd_p1       <= 1'b0;
      wr_p1       <= 1'b0;
      data_to_cpu <= '0;
      irq         <= 1'b0;
    end else begin
      rd_p1       <= rd_req;
      wr_p1       <= wr_req;
      data_to_cpu <= rd_mux;
      irq         <= |(status[BIT_E:BIT_ROE] & ie);

      if (wr_stb && mem_addr == ADDR_STATUS) begin
        roe  <= 1'b0;
        toe  <= 1'b0;
        tue  <= 1'b0;
        rrdy <= 1'b0;
      end
      if (wr_stb && mem_addr == ADDR_CONTROL)
        ie <= data_from_cpu[BIT_E:BIT_ROE];
      if (rd_stb && mem_addr == ADDR_RXDATA)
        rrdy <= 1'b0;

      if (ss_q || load_ev)
        bit_cnt <= '0;
      else if (sclk_rise)
        bit_cnt <= bit_cnt + 4'd1;

      if (sclk_rise && active)
        rx_shift <= rx_next;
      if (rx_done) begin
        rx_holding <= rx_next;
        rrdy       <= 1'b1;
        if (rrdy) roe <= 1'b1;
      end

      if (load_ev) begin
        tx_shift <= primed ? tx_holding : '0;
        primed   <= 1'b0;
        if (!primed) tue <= 1'b1;
      end else if (shift_fall) begin
        tx_shift <= {tx_shift[DATA_W-2:0], 1'b0};
      end

      // A write landing on a load refills the holding register.
      if (wr_stb && mem_addr == ADDR_TXDATA) begin
        if (!primed || load_ev) begin
          tx_holding <= data_from_cpu[DATA_W-1:0];
          primed     <= 1'b1;
        end else begin
          toe <= 1'b1;
        end
      end
    end
  end

  assign MISO          = tx_shift[DATA_W-1];
  assign MISO_oe       = ~ss_q;
  assign dataavailable = rrdy;
  assign readyfordata  = ~primed;

  logic unused_ok;
  assign unused_ok = ^{data_from_cpu[15:9], data_from_cpu[2:0],
                       sclk_q, ss_rise, mosi_rise, mosi_fall};
endmodule

// File: tb/tb_breakout_spi_slave.sv
// Directed bench for breakout_spi_slave: SPI master
// model plus CPU register accesses, hand-computed expectations.
module tb_breakout_spi_slave;
  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        SCLK = 1'b0;
  logic        SS_n = 1'b1;
  logic        MOSI = 1'b0;
  logic        MISO, MISO_oe;
  logic [2:0]  mem_addr = 3'd0;
  logic [15:0] data_from_cpu = 16'h0;
  logic        read_n = 1'b1;
  logic        write_n = 1'b1;
  logic        spi_select = 1'b0;
  logic [15:0] data_to_cpu;
  logic        irq, dataavailable, readyfordata;

  int errors = 0;
  int checks = 0;
  logic [7:0]  mi;
  logic [15:0] rd;

  breakout_spi_slave #(.SYNC_STAGES(2)) dut (
    .clk(clk), .reset_n(reset_n),
    .SCLK(SCLK), .SS_n(SS_n), .MOSI(MOSI),
    .MISO(MISO), .MISO_oe(MISO_oe),
    .mem_addr(mem_addr), .data_from_cpu(data_from_cpu),
    .read_n(read_n), .write_n(write_n), .spi_select(spi_select),
    .data_to_cpu(data_to_cpu), .irq(irq),
    .dataavailable(dataavailable), .readyfordata(readyfordata));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs,
                     input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cpu_write(input logic [2:0] a, input logic [15:0] d);
    @(negedge clk);
    mem_addr = a; data_from_cpu = d;
    spi_select = 1'b1; write_n = 1'b0;
    @(negedge clk);
    write_n = 1'b1; spi_select = 1'b0;
    @(negedge clk);
  endtask

  task automatic cpu_read(input logic [2:0] a, output logic [15:0] d);
    @(negedge clk);
    mem_addr = a; spi_select = 1'b1; read_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    d = data_to_cpu;
    read_n = 1'b1; spi_select = 1'b0;
    @(negedge clk);
  endtask

  // Mode 0: MISO sampled and SCLK raised together; nbits from MSB.
  task automatic spi_bits(input logic [7:0] mo, input int nbits,
                          output logic [7:0] mis);
    mis = 8'h00;
    for (int i = 7; i > 7 - nbits; i--) begin
      MOSI = mo[i];
      #80;
      mis[i] = MISO;
      SCLK = 1'b1;
      #80;
      SCLK = 1'b0;
    end
    #80;
  endtask

  task automatic ss_low();
    SS_n = 1'b0;
    #80;
  endtask

  task automatic ss_high();
    SS_n = 1'b1;
    #80;
  endtask

  initial begin
    #25;
    chk("rst_miso", {15'h0, MISO}, 16'h0);
    chk("rst_oe", {15'h0, MISO_oe}, 16'h0);
    chk("rst_irq", {15'h0, irq}, 16'h0);
    chk("rst_dtc", data_to_cpu, 16'h0);
    chk("rst_rrdy", {15'h0, dataavailable}, 16'h0);
    reset_n = 1'b1;
    #20;
    chk("rst_trdy", {15'h0, readyfordata}, 16'h1);
    cpu_read(3'd2, rd);
    chk("rst_status", rd, 16'h0040);

    // Basic full-duplex byte
    cpu_write(3'd1, 16'h00A5);
    chk("t1_trdy0", {15'h0, readyfordata}, 16'h0);
    ss_low();
    chk("t1_oe", {15'h0, MISO_oe}, 16'h1);
    spi_bits(8'h3C, 8, mi);
    chk("t1_miso", {8'h0, mi}, 16'h00A5);
    ss_high();
    chk("t1_rrdy1", {15'h0, dataavailable}, 16'h1);
    cpu_read(3'd2, rd);
    chk("t1_status", rd, 16'h01E0);
    cpu_read(3'd0, rd);
    chk("t1_rx", rd, 16'h003C);
    chk("t1_rrdy0", {15'h0, dataavailable}, 16'h0);
    cpu_write(3'd2, 16'h0);
    cpu_read(3'd2, rd);
    chk("t1_clr", rd, 16'h0040);

    // Overrun with interrupt
    cpu_write(3'd3, 16'h0008);
    cpu_read(3'd3, rd);
    chk("t2_ctrl", rd, 16'h0008);
    ss_low();
    spi_bits(8'h11, 8, mi);
    spi_bits(8'h22, 8, mi);
    ss_high();
    cpu_read(3'd0, rd);
    chk("t2_rx", rd, 16'h0022);
    cpu_read(3'd2, rd);
    chk("t2_status", rd, 16'h0168);
    chk("t2_irq", {15'h0, irq}, 16'h1);
    cpu_write(3'd2, 16'h0);
    cpu_write(3'd3, 16'h0);
    chk("t2_irq0", {15'h0, irq}, 16'h0);

    // Underrun
    ss_low();
    chk("t3_miso", {15'h0, MISO}, 16'h0);
    cpu_read(3'd2, rd);
    chk("t3_tue", rd, 16'h0160);
    ss_high();
    cpu_write(3'd2, 16'h0);
    cpu_read(3'd2, rd);
    chk("t3_clr", rd, 16'h0040);

    // TX overrun keeps first value
    cpu_write(3'd1, 16'h005A);
    cpu_write(3'd1, 16'h0077);
    cpu_read(3'd2, rd);
    chk("t4_toe", rd, 16'h0110);
    ss_low();
    spi_bits(8'h00, 8, mi);
    ss_high();
    chk("t4_miso", {8'h0, mi}, 16'h005A);
    cpu_read(3'd0, rd);
    cpu_write(3'd2, 16'h0);

    // Aborted partial byte then full byte
    ss_low();
    spi_bits(8'hA0, 4, mi);
    ss_high();
    chk("t5_part", {15'h0, dataavailable}, 16'h0);
    ss_low();
    spi_bits(8'hF0, 8, mi);
    ss_high();
    cpu_read(3'd2, rd);
    chk("t5_status", rd, 16'h01E0);
    cpu_read(3'd0, rd);
    chk("t5_rx", rd, 16'h00F0);
    cpu_write(3'd2, 16'h0);

    // Reset mid-transfer, then clean restart
    cpu_write(3'd3, 16'h0020);
    ss_low();
    spi_bits(8'hFF, 5, mi);
    reset_n = 1'b0;
    #1;
    chk("t6_oe", {15'h0, MISO_oe}, 16'h0);
    chk("t6_miso", {15'h0, MISO}, 16'h0);
    chk("t6_irq", {15'h0, irq}, 16'h0);
    chk("t6_dtc", data_to_cpu, 16'h0);
    chk("t6_rrdy", {15'h0, dataavailable}, 16'h0);
    SS_n = 1'b1;
    SCLK = 1'b0;
    #40;
    reset_n = 1'b1;
    #40;
    ss_low();
    spi_bits(8'h81, 8, mi);
    ss_high();
    chk("t6_rrdy1", {15'h0, dataavailable}, 16'h1);
    cpu_read(3'd0, rd);
    chk("t6_rx", rd, 16'h0081);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
